// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding, port indices and address error check for the data memory arbiter
package dmem_arb_pkg;
  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} own_e;
  localparam int P0 = 0;
  localparam int P1 = 1;
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned mem_aw);
    return (addr[1:0] != 2'd0) || ((addr >> (mem_aw + 2)) != 64'd0);
  endfunction
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way winner pick, core priority with a burst cap when both ports compete
module dmem_rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int BW = 3
) (
  input  logic [1:0]    req,
  input  own_e          owner,
  input  logic [BW-1:0] bcnt,
  output logic [1:0]    win
);
  always_comb
    win = (req == 2'b11) ? ((bcnt == BW'(MAX_BURST) && owner == OWN0) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the LSU (port 0) and a DMA/debug loader (port 1)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [31:0]       mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam int BW = $clog2(MAX_BURST + 1);
  own_e              owner, win_own;
  logic [BW-1:0]     bcnt;
  logic [1:0]        win, gnt;
  logic              go, sel, we, err, clean;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  dmem_rr_pick #(.MAX_BURST(MAX_BURST), .BW(BW)) u_pick (
    .req  ({p1_req, p0_req}),
    .owner(owner),
    .bcnt (bcnt),
    .win  (win)
  );
  // reset gates grants combinationally so no write can land while rst is low
  always_comb begin
    gnt     = rst ? win : 2'b00;
    go      = |gnt;
    sel     = gnt[P1];
    addr    = sel ? p1_addr : p0_addr;
    we      = sel ? p1_we : p0_we;
    wdata   = sel ? p1_wdata : p0_wdata;
    err     = go && addr_err(64'(addr), MEM_AW);
    clean   = go && !err;
    mem_we  = clean && we;
    mem_a   = clean ? 32'(addr[MEM_AW+1:2]) : 32'd0;
    mem_wd  = mem_we ? wdata : '0;
    win_own = sel ? OWN1 : OWN0;
  end
  assign p0_gnt = gnt[P0];
  assign p1_gnt = gnt[P1];
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner     <= OWN1;
      bcnt      <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= gnt[P0];
      p1_rvalid <= gnt[P1];
      p0_err    <= gnt[P0] && err;
      p1_err    <= gnt[P1] && err;
      p0_rdata  <= (gnt[P0] && clean && !we) ? mem_rd : '0;
      p1_rdata  <= (gnt[P1] && clean && !we) ? mem_rd : '0;
      if (go) begin
        owner <= win_own;
        bcnt  <= (win_own != owner) ? BW'(1) : (bcnt == BW'(MAX_BURST)) ? bcnt : bcnt + 1'b1;
      end
    end
  end
endmodule
